lsu: RTL and testbench
======================

# lsu

Load/store unit of the RV64I execute path, directly downstream of the ALU: it takes the effective address produced by the ALU (rs1 + imm, ALU_ADD) together with the store data and funct3, and performs one doubleword-bus memory transaction. Its responsibilities are:
- byte-lane steering and write strobes;
- misalignment and illegal-width detection;
- load sign/zero extension.

It returns the result to the writeback stage through a valid/ready handshake.

## Interface
- DATA_WIDTH, 64, data/address width; only 64 is supported.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  1  execute stage presents an access.
- req_ready_o  output  1  lsu can accept; high only in IDLE.
- req_store_i  input  1  1 = store, 0 = load.
- req_funct3_i  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- req_addr_i  input  64  effective address (ALU output).
- req_wdata_i  input  64  store data, right-aligned (rs2).
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  write enable.
- mem_addr_o  output  64  doubleword-aligned address, {addr[63:3], 3'b000}.
- mem_wdata_o  output  64  store data shifted to its byte lanes.
- mem_wstrb_o  output  8  byte write strobes; 0 on loads.
- mem_ack_i  input  1  memory completes the request; for loads, mem_rdata_i is valid in the same cycle.
- mem_rdata_i  input  64  read doubleword.
- resp_valid_o  output  1  result available.
- resp_ready_i  input  1  writeback accepts the result.
- resp_rdata_o  output  64  extended load data; 0 for stores and faults.
- resp_fault_o  output  1  misaligned address or illegal funct3; no memory access was made.

## Operation
- **FSM states:** IDLE, MEM, RESP.
- **IDLE:**
  - req_ready_o = 1.
  - On req_valid_i, register addr, funct3, store flag and steered data/strobes.
  - Fault check: go to RESP with fault = 1.
  - Otherwise go to MEM.
- **Fault conditions:**
  - funct3 = 111.
  - Store with funct3[2] = 1.
  - H access with addr[0] ≠ 0.
  - W access with addr[1:0] ≠ 0.
  - D access with addr[2:0] ≠ 0.
- **MEM:**
  - mem_req_o = 1, with mem_* outputs held stable from registers until mem_ack_i.
  - On mem_ack_i, capture mem_rdata_i (loads) and go to RESP.
- **RESP:**
  - resp_valid_o = 1, with data and fault held stable.
  - On resp_ready_i, go to IDLE.
- **Store steering, with o = addr[2:0]:**
  - mem_wdata_o = wdata << (8·o).
  - mem_wstrb_o: B = 1 << o; H = 3 << o; W = 0x0F << o; D = 0xFF.
- **Load extraction:**
  - byte = rdata >> (8·o), truncated to the access width.
  - B/H/W are sign-extended; BU/HU/WU are zero-extended; D is passed through.
- Stores complete with resp_rdata_o = 0 (writeback ignores it).

## Timing
- **Reset:** state = IDLE. Outputs after reset:
  - req_ready_o = 1.
  - mem_req_o, mem_we_o, resp_valid_o, resp_fault_o = 0.
  - mem_addr_o, mem_wdata_o, resp_rdata_o = 0.
  - mem_wstrb_o = 0.
- **Latency**, with the request accepted at cycle 0:
  - mem_req_o is high from cycle 1.
  - If ack arrives in cycle k ≥ 1, resp_valid_o is high from cycle k+1.
  - Minimum request-to-response latency is 2 cycles.
  - A faulting request asserts resp_valid_o in cycle 1 and never raises mem_req_o.
- **Throughput:** one access in flight. req_ready_o is low in MEM and RESP, and a new request can be accepted in the cycle after the response handshake.
- **Ordering:** mem_ack_i is ignored outside MEM.
- **Reset mid-operation:** rst_i in MEM or RESP forces IDLE at the next edge. mem_req_o and resp_valid_o drop and the access is abandoned; no response is produced.
- **No combinational paths:** nothing runs from mem_ack_i or resp_ready_i to any output; all outputs are registered or decoded from state.

## Test plan
- **Aligned LW, sign extension:** addr = 0x1004, funct3 = 010, mem_rdata_i = 0x8000_0001_0000_0000 with ack in cycle 3.
  - Expect mem_addr_o = 0x1000 and mem_wstrb_o = 0 in cycles 1–3.
  - Expect resp_rdata_o = 0xFFFF_FFFF_8000_0001 and resp_valid_o in cycle 4.
- **SB lane steering:** addr = 0x2003, funct3 = 000, wdata = 0xAB.
  - Expect mem_wdata_o = 0x0000_0000_AB00_0000, mem_wstrb_o = 0x08, mem_we_o = 1.
  - Expect a response with fault = 0.
- **LBU/LHU zero extension:**
  - LBU at addr = 0x7, rdata = 0xFF00…00: expect 0xFF.
  - LHU at addr = 0x2, rdata = 0x0000_0000_8001_0000: expect 0x8001.
- **Faults:**
  - LD at 0x1004 → resp_fault_o = 1 in cycle 1, mem_req_o never high.
  - SW with funct3 = 110 → fault.
  - funct3 = 111 → fault.
- **Backpressure:** hold resp_ready_i low for 5 cycles after a load response.
  - Expect resp_valid_o and resp_rdata_o stable.
  - Expect req_ready_o = 0 throughout.
  - A req_valid_i asserted meanwhile is not accepted until the cycle after the handshake.
- **Reset mid-access:** assert rst_i while in MEM with ack withheld.
  - Expect all outputs at reset values next cycle.
  - A late mem_ack_i is ignored; the next request is handled normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit for the RV64I execute path.
//
// Takes an effective address, store data and funct3 from execute and performs
// one doubleword-bus access. It steers store data onto its byte lanes, builds
// the write strobes and rejects misaligned or illegal-width accesses without
// touching memory. Loaded data is sign- or zero-extended. The result goes to
// writeback over a valid/ready handshake. Only one access is in flight.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_*               request from execute (valid/ready, store, funct3, addr, wdata)
//   mem_*               doubleword memory bus (req, we, addr, wdata, wstrb, ack, rdata)
//   resp_*              response to writeback (valid/ready, rdata, fault)
//
// Every output is a register or is decoded from the state register. Nothing
// depends combinationally on mem_ack_i or resp_ready_i.
module lsu #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [7:0]            mem_wstrb_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_fault_o
);

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0]            wstrb_q;
  logic [2:0]            funct3_q;
  logic                  store_q;
  logic                  fault_q;

  logic [2:0]            req_off;
  logic                  req_fault;
  logic [7:0]            req_wstrb;
  logic [DATA_WIDTH-1:0] req_wdata_steered;

  // Sign/zero extension of the addressed lane. funct3[2] selects unsigned.
  function automatic logic [63:0] load_extract(input logic [63:0] rdata,
                                               input logic [2:0]  off,
                                               input logic [2:0]  f3);
    logic [63:0] sh;
    sh = rdata >> {off, 3'b000};
    unique case (f3[1:0])
      2'b00:   return f3[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'b01:   return f3[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10:   return f3[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  // Request decode: fault check, strobes and lane steering.
  always_comb begin
    req_off           = req_addr_i[2:0];
    req_wdata_steered = req_wdata_i << {req_off, 3'b000};
    req_fault         = 1'b0;
    req_wstrb         = 8'h00;

    unique case (req_funct3_i[1:0])
      2'b00: req_wstrb = 8'h01 << req_off;
      2'b01: begin
        req_wstrb = 8'h03 << req_off;
        req_fault = req_off[0];
      end
      2'b10: begin
        req_wstrb = 8'h0F << req_off;
        req_fault = |req_off[1:0];
      end
      default: begin
        req_wstrb = 8'hFF;
        req_fault = |req_off;
      end
    endcase

    // 111 is reserved; unsigned widths exist only for loads.
    if (req_funct3_i == 3'b111 || (req_store_i && req_funct3_i[2])) begin
      req_fault = 1'b1;
    end
    if (!req_store_i) begin
      req_wstrb = 8'h00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wstrb_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i;
            funct3_q <= req_funct3_i;
            store_q  <= req_store_i;
            wdata_q  <= req_wdata_steered;
            wstrb_q  <= req_wstrb;
            fault_q  <= req_fault;
            rdata_q  <= '0;
            state_q  <= req_fault ? StResp : StMem;
          end
        end
        StMem: begin
          if (mem_ack_i) begin
            if (!store_q) begin
              rdata_q <= load_extract(mem_rdata_i, addr_q[2:0], funct3_q);
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign mem_req_o    = (state_q == StMem);
  assign mem_we_o     = (state_q == StMem) && store_q;
  assign mem_addr_o   = {addr_q[DATA_WIDTH-1:3], 3'b000};
  assign mem_wdata_o  = wdata_q;
  assign mem_wstrb_o  = wstrb_q;
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign resp_fault_o = fault_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu. Inputs change and outputs are sampled 1 time unit
// after each rising edge. "Cycle n" is the cycle following the n-th edge
// after the request was presented.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_fault;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  lsu #(.DATA_WIDTH(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_store_i  (req_store),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wstrb_o  (mem_wstrb),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_fault_o (resp_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in cycle 1.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd);
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic ack(input logic [63:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack   = 1'b0;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    check({tag, ".mem_req"}, 64'(mem_req), 64'd0);
    check({tag, ".mem_we"}, 64'(mem_we), 64'd0);
    check({tag, ".resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, ".resp_fault"}, 64'(resp_fault), 64'd0);
    check({tag, ".mem_addr"}, mem_addr, 64'd0);
    check({tag, ".mem_wdata"}, mem_wdata, 64'd0);
    check({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'd0);
    check({tag, ".resp_rdata"}, resp_rdata, 64'd0);
  endtask

  // Load with immediate ack in cycle 1; checks the extended result.
  task automatic load_vec(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] rd, input logic [63:0] exp);
    do_req(1'b0, f3, a, 64'd0);
    ack(rd);
    check({tag, ".valid"}, 64'(resp_valid), 64'd1);
    check({tag, ".rdata"}, resp_rdata, exp);
    check({tag, ".fault"}, 64'(resp_fault), 64'd0);
    handshake();
  endtask

  task automatic store_vec(input string tag, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input logic [63:0] exp_wd,
                           input logic [7:0] exp_st);
    do_req(1'b1, f3, a, wd);
    check({tag, ".mem_req"}, 64'(mem_req), 64'd1);
    check({tag, ".mem_we"}, 64'(mem_we), 64'd1);
    check({tag, ".mem_addr"}, mem_addr, {a[63:3], 3'b000});
    check({tag, ".mem_wdata"}, mem_wdata, exp_wd);
    check({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'(exp_st));
    ack(64'hDEAD_BEEF_DEAD_BEEF);
    check({tag, ".valid"}, 64'(resp_valid), 64'd1);
    check({tag, ".fault"}, 64'(resp_fault), 64'd0);
    check({tag, ".rdata"}, resp_rdata, 64'd0);
    handshake();
  endtask

  // Faulting request: response in cycle 1, no memory access.
  task automatic fault_vec(input string tag, input logic st, input logic [2:0] f3,
                           input logic [63:0] a);
    do_req(st, f3, a, 64'h1122_3344_5566_7788);
    check({tag, ".valid"}, 64'(resp_valid), 64'd1);
    check({tag, ".fault"}, 64'(resp_fault), 64'd1);
    check({tag, ".mem_req"}, 64'(mem_req), 64'd0);
    check({tag, ".rdata"}, resp_rdata, 64'd0);
    handshake();
    check({tag, ".idle_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Aligned LW with ack in cycle 3.
    do_req(1'b0, 3'b010, 64'h1004, 64'd0);
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("lw.c%0d.mem_req", c), 64'(mem_req), 64'd1);
      check($sformatf("lw.c%0d.mem_addr", c), mem_addr, 64'h1000);
      check($sformatf("lw.c%0d.mem_wstrb", c), 64'(mem_wstrb), 64'd0);
      check($sformatf("lw.c%0d.mem_we", c), 64'(mem_we), 64'd0);
      check($sformatf("lw.c%0d.req_ready", c), 64'(req_ready), 64'd0);
      check($sformatf("lw.c%0d.resp_valid", c), 64'(resp_valid), 64'd0);
      if (c < 3) step();
    end
    ack(64'h8000_0001_0000_0000);
    check("lw.c4.valid", 64'(resp_valid), 64'd1);
    check("lw.c4.rdata", resp_rdata, 64'hFFFF_FFFF_8000_0001);
    check("lw.c4.mem_req", 64'(mem_req), 64'd0);
    handshake();
    check("lw.idle_ready", 64'(req_ready), 64'd1);

    // Stores: lane steering and strobes.
    store_vec("sb", 3'b000, 64'h2003, 64'hAB, 64'h0000_0000_AB00_0000, 8'h08);
    store_vec("sh", 3'b001, 64'h2006, 64'h1234, 64'h1234_0000_0000_0000, 8'hC0);
    store_vec("sw", 3'b010, 64'h2004, 64'hCAFE_F00D, 64'hCAFE_F00D_0000_0000, 8'hF0);
    store_vec("sd", 3'b011, 64'h2008, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708,
              8'hFF);

    // Loads: zero and sign extension.
    load_vec("lbu", 3'b100, 64'h7, 64'hFF00_0000_0000_0000, 64'h0000_0000_0000_00FF);
    load_vec("lb",  3'b000, 64'h7, 64'hFF00_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    load_vec("lhu", 3'b101, 64'h2, 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001);
    load_vec("lh",  3'b001, 64'h2, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
    load_vec("ld",  3'b011, 64'h8, 64'h8765_4321_0FED_CBA9, 64'h8765_4321_0FED_CBA9);

    // Faults.
    fault_vec("f_ld_mis", 1'b0, 3'b011, 64'h1004);
    fault_vec("f_sw_u",   1'b1, 3'b110, 64'h1000);
    fault_vec("f_111",    1'b0, 3'b111, 64'h1000);
    fault_vec("f_lh_mis", 1'b0, 3'b001, 64'h1001);

    // Backpressure with a competing request held valid.
    do_req(1'b0, 3'b011, 64'h3000, 64'd0);
    ack(64'h0123_4567_89AB_CDEF);
    req_store = 1'b0; req_funct3 = 3'b010; req_addr = 64'h5004; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp.c%0d.valid", c), 64'(resp_valid), 64'd1);
      check($sformatf("bp.c%0d.rdata", c), resp_rdata, 64'h0123_4567_89AB_CDEF);
      check($sformatf("bp.c%0d.req_ready", c), 64'(req_ready), 64'd0);
      check($sformatf("bp.c%0d.mem_req", c), 64'(mem_req), 64'd0);
      step();
    end
    handshake();
    check("bp.after_hs.req_ready", 64'(req_ready), 64'd1);
    check("bp.after_hs.mem_req", 64'(mem_req), 64'd0);
    check("bp.after_hs.valid", 64'(resp_valid), 64'd0);
    step();
    req_valid = 1'b0;
    check("bp.accept.mem_req", 64'(mem_req), 64'd1);
    check("bp.accept.mem_addr", mem_addr, 64'h5000);
    ack(64'h0000_0001_0000_0000);
    check("bp.resp.rdata", resp_rdata, 64'h0000_0000_0000_0001);
    handshake();

    // Reset while in MEM, then a late ack.
    do_req(1'b1, 3'b010, 64'h4008, 64'h5555_AAAA);
    check("rst.pre.mem_req", 64'(mem_req), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("rst.mid");
    ack(64'hFFFF_FFFF_FFFF_FFFF);
    check("rst.late_ack.valid", 64'(resp_valid), 64'd0);
    check("rst.late_ack.mem_req", 64'(mem_req), 64'd0);
    check("rst.late_ack.ready", 64'(req_ready), 64'd1);
    load_vec("rst.lwu", 3'b110, 64'h10, 64'h0000_0000_F000_0000, 64'h0000_0000_F000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
